hazard_ctrl: RTL and testbench
==============================

// Module: hazard_ctrl
// PURPOSE
//  Pipeline sequencer for the IF/ID/EX/MB/WB integer core. Detects load-use hazards
//  that the EX forwarding unit cannot cover, and inserts a bubble for them. Sequences
//  the multi-cycle mul/div unit that shares the EX slot. Drives pipe_flush on taken
//  branches resolved in MB. Sits beside the pipeline registers and feeds their stall,
//  bubble and flush controls.
// PARAMETERS
//  FLUSH_CYCLES  2   cycles pipe_flush is held per redirect (>=1)
//  MD_TIMEOUT    64  max MD_WAIT cycles before abort (>=2)
//  CNT_W         32  width of stall_cycles performance counter
// PORTS
//  clk                   in   1      clock
//  rst                   in   1      synchronous reset, active-high
//  if_id__rs1_addr       in   5      source reg 1 of instr in ID
//  if_id__rs2_addr       in   5      source reg 2 of instr in ID
//  id_ex__rd_addr        in   5      dest reg of instr in EX
//  id_ex__mem_read       in   1      instr in EX is a load
//  id_ex__muldiv         in   1      instr in EX is a mul/div op
//  muldiv_done           in   1      mul/div result valid (single-cycle pulse)
//  ex_mb__branch_taken   in   1      redirect resolved in MB
//  pc_stall              out  1      hold PC
//  if_id__stall          out  1      hold IF/ID register
//  id_ex__stall          out  1      hold ID/EX register
//  id_ex__bubble         out  1      load NOP into ID/EX
//  pipe_flush            out  1      squash wrong-path instrs (to execute and earlier)
//  muldiv_start          out  1      one-cycle start pulse to mul/div unit
//  muldiv_kill           out  1      one-cycle abort pulse to mul/div unit
//  md_timeout            out  1      sticky: a mul/div exceeded MD_TIMEOUT
//  stall_cycles          out  CNT_W  count of cycles with pc_stall=1, saturating
// BEHAVIOUR
//  - Reset: state=RUN; flush_cnt=0; md_cnt=0; md_timeout=0; stall_cycles=0.
//    All combinational outputs are 0 while in RUN with idle inputs. Reset mid-MD_WAIT
//    or mid-FLUSH returns to RUN with no kill pulse.
//  - States: RUN, MD_WAIT, FLUSH. Priority in any state: redirect > mul/div > load-use.
//  - Load-use (RUN only): hit = id_ex__mem_read && rd!=0 && (rd==rs1 || rd==rs2).
//    On a hit, in the same cycle: pc_stall=if_id__stall=id_ex__bubble=1. No state
//    change; the bubble clears the hazard on the next cycle. Exactly 1 stall cycle.
//  - Mul/div: RUN with id_ex__muldiv=1 (no redirect) sets muldiv_start=1 and all three
//    stalls=1 in that cycle, then moves to MD_WAIT with md_cnt=0. MD_WAIT holds all
//    three stalls while muldiv_done=0; md_cnt increments each cycle.
//    muldiv_done=1: stalls drop in that same cycle and the state goes to RUN.
//    md_cnt==MD_TIMEOUT-1 without done: muldiv_kill=1, md_timeout<=1, go to RUN.
//    Done and timeout in the same cycle: done wins, no kill.
//  - Redirect: ex_mb__branch_taken in RUN or MD_WAIT sets pipe_flush=1 the same cycle.
//    It then goes to FLUSH with flush_cnt=FLUSH_CYCLES-1 (stays in RUN if FLUSH_CYCLES=1).
//    If taken in MD_WAIT, also muldiv_kill=1 and stalls=0 (the mul/div is wrong-path).
//    FLUSH: pipe_flush=1, flush_cnt decrements, state goes to RUN after the cycle where
//    flush_cnt==1. Total pipe_flush high = FLUSH_CYCLES cycles.
//  - In FLUSH, branch_taken, id_ex__muldiv and load-use are ignored (wrong-path);
//    no stall or start is issued.
//  - stall_cycles += 1 on each cycle with pc_stall=1; holds at 2^CNT_W-1.
//  - muldiv_start never asserts in two consecutive cycles.
// TESTING
//  1 lw x5 in EX, ID reads x5 -> one cycle with pc_stall/if_id__stall/id_ex__bubble=1,
//    stall_cycles=1; same pattern with rd=x0 -> no stall.
//  2 mul in EX, done after 5 cycles -> start pulse at t0, stalls high t0..t5,
//    low at done cycle t6?no: stalls low in the done cycle; stall_cycles=6.
//  3 branch_taken in RUN, FLUSH_CYCLES=2 -> pipe_flush high exactly 2 cycles; a
//    load-use or muldiv hit during the 2nd cycle produces no stall or start.
//  4 branch_taken on MD_WAIT cycle 3 -> muldiv_kill pulse, stalls drop, pipe_flush 2 cycles.
//  5 mul never done, MD_TIMEOUT=64 -> kill on cycle 64 of MD_WAIT, md_timeout sticky
//    until rst; done and timeout together -> no kill.
//  6 rst asserted mid-MD_WAIT -> next cycle: RUN, outputs 0, counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencer for load-use bubbles, mul/div stalls and branch flushes.
// Stall/bubble/flush controls are combinational so they act in the cycle the condition is seen.
module hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int MD_TIMEOUT   = 64,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       if_id__rs1_addr,
    input  logic [4:0]       if_id__rs2_addr,
    input  logic [4:0]       id_ex__rd_addr,
    input  logic             id_ex__mem_read,
    input  logic             id_ex__muldiv,
    input  logic             muldiv_done,
    input  logic             ex_mb__branch_taken,
    output logic             pc_stall,
    output logic             if_id__stall,
    output logic             id_ex__stall,
    output logic             id_ex__bubble,
    output logic             pipe_flush,
    output logic             muldiv_start,
    output logic             muldiv_kill,
    output logic             md_timeout,
    output logic [CNT_W-1:0] stall_cycles
);
    localparam int MW = $clog2(MD_TIMEOUT);
    localparam int FW = $clog2(FLUSH_CYCLES + 1);
    localparam logic [MW-1:0] MD_LAST = MW'(MD_TIMEOUT - 1);
    localparam logic [FW-1:0] FL_INIT = FW'(FLUSH_CYCLES - 1);
    typedef enum logic [1:0] {RUN, MD_WAIT, FLUSH} state_t;
    state_t state;
    logic [MW-1:0] md_cnt;
    logic [FW-1:0] flush_cnt;
    logic in_run, in_wait, in_flush, redirect, lu_hit, lu_stall, md_hold, timeout_hit;
    always_comb begin
        in_run        = state == RUN;
        in_wait       = state == MD_WAIT;
        in_flush      = state == FLUSH;
        redirect      = ex_mb__branch_taken && !in_flush;
        lu_hit        = id_ex__mem_read && id_ex__rd_addr != 5'd0 &&
                        (id_ex__rd_addr == if_id__rs1_addr || id_ex__rd_addr == if_id__rs2_addr);
        muldiv_start  = in_run && !redirect && id_ex__muldiv;
        lu_stall      = in_run && !redirect && !id_ex__muldiv && lu_hit;
        md_hold       = muldiv_start || (in_wait && !redirect && !muldiv_done);
        timeout_hit   = in_wait && !redirect && !muldiv_done && md_cnt == MD_LAST;
        pc_stall      = md_hold || lu_stall;
        if_id__stall  = md_hold || lu_stall;
        id_ex__stall  = md_hold;
        id_ex__bubble = lu_stall;
        pipe_flush    = redirect || in_flush;
        muldiv_kill   = (in_wait && redirect) || timeout_hit;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= RUN;
            flush_cnt    <= '0;
            md_cnt       <= '0;
            md_timeout   <= 1'b0;
            stall_cycles <= '0;
        end else begin
            if (pc_stall && !(&stall_cycles)) stall_cycles <= stall_cycles + CNT_W'(1);
            if (timeout_hit) md_timeout <= 1'b1;
            if (redirect) begin
                flush_cnt <= FL_INIT;
                state     <= FLUSH_CYCLES > 1 ? FLUSH : RUN;
            end else if (muldiv_start) begin
                md_cnt <= '0;
                state  <= MD_WAIT;
            end else if (in_wait) begin
                md_cnt <= md_cnt + MW'(1);
                if (muldiv_done || timeout_hit) state <= RUN;
            end else if (in_flush) begin
                flush_cnt <= flush_cnt - FW'(1);
                if (flush_cnt == FW'(1)) state <= RUN;
            end
        end
    end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed checks of hazard_ctrl with hand-computed expectations.
// Output vector order: {pc_stall, if_id__stall, id_ex__stall, id_ex__bubble, pipe_flush, muldiv_start, muldiv_kill, md_timeout}.
module tb_hazard_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
    logic       mr = 1'b0, md = 1'b0, dn = 1'b0, br = 1'b0;
    logic       pc_stall, if_id__stall, id_ex__stall, id_ex__bubble;
    logic       pipe_flush, muldiv_start, muldiv_kill, md_timeout;
    logic [3:0] stall_cycles;
    logic [7:0] outs;
    int         vectors = 0;
    int         miscompares = 0;

    hazard_ctrl #(.FLUSH_CYCLES(2), .MD_TIMEOUT(64), .CNT_W(4)) dut (
        .clk(clk), .rst(rst),
        .if_id__rs1_addr(rs1), .if_id__rs2_addr(rs2), .id_ex__rd_addr(rd),
        .id_ex__mem_read(mr), .id_ex__muldiv(md), .muldiv_done(dn),
        .ex_mb__branch_taken(br),
        .pc_stall(pc_stall), .if_id__stall(if_id__stall), .id_ex__stall(id_ex__stall),
        .id_ex__bubble(id_ex__bubble), .pipe_flush(pipe_flush),
        .muldiv_start(muldiv_start), .muldiv_kill(muldiv_kill),
        .md_timeout(md_timeout), .stall_cycles(stall_cycles)
    );

    assign outs = {pc_stall, if_id__stall, id_ex__stall, id_ex__bubble,
                   pipe_flush, muldiv_start, muldiv_kill, md_timeout};

    always #5 clk = ~clk;

    task automatic drive(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                         input logic m, input logic u, input logic k, input logic t);
        @(posedge clk);
        #1;
        rs1 = a; rs2 = b; rd = d; mr = m; md = u; dn = k; br = t;
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        drive(0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("reset_outs", 32'(outs), 32'h00);
        chk("reset_cnt", 32'(stall_cycles), 0);
        rst = 1'b0;
        // load-use
        drive(5, 0, 5, 1, 0, 0, 0);
        chk("lu_rs1", 32'(outs), 32'hD0);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("lu_one_cycle", 32'(outs), 32'h00);
        chk("lu_cnt", 32'(stall_cycles), 1);
        drive(0, 0, 0, 1, 0, 0, 0);
        chk("lu_x0", 32'(outs), 32'h00);
        drive(1, 7, 7, 1, 0, 0, 0);
        chk("lu_rs2", 32'(outs), 32'hD0);
        drive(1, 2, 3, 1, 0, 0, 0);
        chk("lu_nomatch", 32'(outs), 32'h00);
        chk("lu_cnt2", 32'(stall_cycles), 2);
        drive(5, 5, 5, 0, 0, 0, 0);
        chk("lu_not_load", 32'(outs), 32'h00);
        // mul/div done after 5 wait cycles
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("md_start", 32'(outs), 32'hE4);
        for (int i = 1; i <= 5; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("md_wait", 32'(outs), 32'hE0);
        end
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("md_done", 32'(outs), 32'h00);
        chk("md_cnt", 32'(stall_cycles), 8);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("md_idle", 32'(outs), 32'h00);
        // redirect in RUN, wrong-path hazards ignored during FLUSH
        drive(0, 0, 0, 0, 0, 0, 1);
        chk("br_run", 32'(outs), 32'h08);
        drive(5, 0, 5, 1, 1, 0, 1);
        chk("br_flush2", 32'(outs), 32'h08);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("br_end", 32'(outs), 32'h00);
        chk("br_cnt", 32'(stall_cycles), 8);
        // redirect during MD_WAIT cycle 3
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("mdbr_start", 32'(outs), 32'hE4);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("mdbr_w1", 32'(outs), 32'hE0);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("mdbr_w2", 32'(outs), 32'hE0);
        drive(0, 0, 0, 0, 1, 0, 1);
        chk("mdbr_kill", 32'(outs), 32'h0A);
        chk("mdbr_cnt", 32'(stall_cycles), 11);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mdbr_flush2", 32'(outs), 32'h08);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("mdbr_end", 32'(outs), 32'h00);
        // timeout: kill on MD_WAIT cycle 64, counter saturates
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("to_start", 32'(outs), 32'hE4);
        for (int i = 1; i <= 63; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("to_wait", 32'(outs), 32'hE0);
        end
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("to_kill", 32'(outs), 32'hE2);
        chk("to_cnt_sat", 32'(stall_cycles), 15);
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("to_sticky", 32'(outs), 32'h01);
        // done on the timeout cycle wins
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("dt_start", 32'(outs), 32'hE5);
        for (int i = 1; i <= 63; i++) begin
            drive(0, 0, 0, 0, 1, 0, 0);
            chk("dt_wait", 32'(outs), 32'hE1);
        end
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("dt_done_wins", 32'(outs), 32'h01);
        chk("dt_cnt_hold", 32'(stall_cycles), 15);
        // reset in the middle of MD_WAIT
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("rs_start", 32'(outs), 32'hE5);
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("rs_wait", 32'(outs), 32'hE1);
        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        chk("rs_outs", 32'(outs), 32'h00);
        chk("rs_cnt", 32'(stall_cycles), 0);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1, 0, 0);
        chk("rs_run_start", 32'(outs), 32'hE4);
        drive(0, 0, 0, 0, 1, 1, 0);
        chk("rs_run_done", 32'(outs), 32'h00);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
